// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver: oversamples SCL/SDA, matches a 7-bit address,
// ACKs by pulling SDA low and strobes out each received data byte.
module i2c_target_rx #(
    parameter logic [6:0] ADDR        = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       busy,
    output logic       stop_pulse
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
    localparam logic [2:0] S_DATA_ACK = 3'd4;
    localparam logic [2:0] S_IGNORE   = 3'd5;

    // Synchronisers idle high so reset never looks like a START/STOP.
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic sda_rise;
    logic sda_fall;
    logic start_det;
    logic stop_det;

    logic [2:0] state_q,      state_d;
    logic [7:0] shift_q,      shift_d;
    logic [3:0] bitcnt_q,     bitcnt_d;
    logic       first_q,      first_d;
    logic       sda_oe_q,     sda_oe_d;
    logic       busy_q,       busy_d;
    logic [7:0] rx_data_q,    rx_data_d;
    logic       rx_valid_q,   rx_valid_d;
    logic       rx_first_q,   rx_first_d;
    logic       stop_pulse_q, stop_pulse_d;

    logic [7:0] shift_in;
    logic [3:0] bitcnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign sda_rise  = sda_s & ~sda_prev_q;
    assign sda_fall  = ~sda_s & sda_prev_q;
    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;

    assign shift_in   = {shift_q[6:0], sda_s};
    assign bitcnt_inc = bitcnt_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bitcnt_d     = bitcnt_q;
        first_d      = first_q;
        sda_oe_d     = sda_oe_q;
        busy_d       = busy_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_first_d   = 1'b0;
        stop_pulse_d = 1'b0;

        if (start_det) begin
            state_d  = S_ADDR;
            shift_d  = 8'h00;
            bitcnt_d = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (stop_det) begin
            state_d      = S_IDLE;
            bitcnt_d     = 4'd0;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b0;
            stop_pulse_d = busy_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                end
                S_ADDR: begin
                    if (scl_rise && bitcnt_q < 4'd8) begin
                        shift_d  = shift_in;
                        bitcnt_d = bitcnt_inc;
                        if (bitcnt_inc == 4'd8) begin
                            if (shift_in[7:1] == ADDR && !shift_in[0]) begin
                                state_d = S_ADDR_ACK;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end
                    end
                end
                // sda_oe itself tells which of the two ACK-window falls this is.
                S_ADDR_ACK, S_DATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = S_DATA;
                            bitcnt_d = 4'd0;
                            if (state_q == S_ADDR_ACK) begin
                                first_d = 1'b1;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (scl_rise && bitcnt_q < 4'd8) begin
                        shift_d  = shift_in;
                        bitcnt_d = bitcnt_inc;
                        if (bitcnt_inc == 4'd8) begin
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                            rx_first_d = first_q;
                            first_d    = 1'b0;
                            state_d    = S_DATA_ACK;
                        end
                    end
                end
                S_IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = S_IDLE;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            shift_q      <= 8'h00;
            bitcnt_q     <= 4'd0;
            first_q      <= 1'b0;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_first_q   <= 1'b0;
            stop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bitcnt_q     <= bitcnt_d;
            first_q      <= first_d;
            sda_oe_q     <= sda_oe_d;
            busy_q       <= busy_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_first_q   <= rx_first_d;
            stop_pulse_q <= stop_pulse_d;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_first   = rx_first_q;
    assign busy       = busy_q;
    assign stop_pulse = stop_pulse_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: bit-banged I2C master on a wired-AND SDA line.
module tb_i2c_target_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    wire        sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic       busy;
    logic       stop_pulse;

    int vec_cnt = 0;
    int err_cnt = 0;
    int half = 20;
    bit glitch = 1'b0;

    // Bus monitor state, written only by the negedge monitor.
    logic [8:0] rx_log [0:31];
    int rx_cnt = 0;
    int stop_cnt = 0;
    int busy_cnt = 0;
    int ack_cnt = 0;
    int long_cnt = 0;
    int oe_viol = 0;
    logic oe_prev = 1'b0;
    logic valid_prev = 1'b0;

    always #5 clk = ~clk;

    assign sda_bus = sda_drv & ~sda_oe;

    i2c_target_rx #(.ADDR(7'h3C), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_in     (scl_drv),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_first   (rx_first),
        .busy       (busy),
        .stop_pulse (stop_pulse)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt[4:0]] <= {rx_first, rx_data};
            rx_cnt <= rx_cnt + 1;
            if (valid_prev) long_cnt <= long_cnt + 1;
        end
        valid_prev <= rx_valid;
        if (stop_pulse) stop_cnt <= stop_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (sda_oe && !oe_prev) ack_cnt <= ack_cnt + 1;
        if ((sda_oe !== oe_prev) && scl_drv && rst_n) oe_viol <= oe_viol + 1;
        oe_prev <= sda_oe;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1;
        wait_clk(half);
        scl_drv = 1'b1;
        wait_clk(half);
        sda_drv = 1'b0;
        wait_clk(half);
        scl_drv = 1'b0;
        wait_clk(half / 2);
    endtask

    task automatic i2c_stop();
        wait_clk(half / 2);
        sda_drv = 1'b0;
        wait_clk(half / 2);
        scl_drv = 1'b1;
        wait_clk(half);
        sda_drv = 1'b1;
        wait_clk(half);
    endtask

    // Entered and left with SCL low.
    task automatic send_bit(input logic b);
        wait_clk(half / 2);
        if (glitch) begin
            for (int k = 0; k < 3; k++) begin
                sda_drv = ~sda_drv;
                wait_clk(2);
            end
        end
        sda_drv = b;
        wait_clk(half / 2);
        scl_drv = 1'b1;
        wait_clk(half);
        scl_drv = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        wait_clk(half / 2);
        sda_drv = 1'b1;
        wait_clk(half / 2);
        scl_drv = 1'b1;
        wait_clk(half / 2);
        ack = sda_oe;
        wait_clk(half - half / 2);
        scl_drv = 1'b0;
    endtask

    initial begin
        logic ack;
        int rx0, st0, by0, ak0;

        // Reset state
        wait_clk(4);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stop_pulse", stop_pulse, 0);
        chk("rst_rx_data", rx_data, 0);
        rst_n = 1'b1;
        wait_clk(10);

        // 1: write 0x78, 0x00, 0xAF at a slow SCL
        half = 350;
        rx0 = rx_cnt; st0 = stop_cnt; ak0 = ack_cnt;
        i2c_start();
        send_byte(8'h78, ack); chk("t1_ack_addr", ack, 1);
        chk("t1_busy", busy, 1);
        send_byte(8'h00, ack); chk("t1_ack_d0", ack, 1);
        send_byte(8'hAF, ack); chk("t1_ack_d1", ack, 1);
        i2c_stop();
        wait_clk(4);
        chk("t1_rx_count", rx_cnt - rx0, 2);
        chk("t1_byte0", rx_log[rx0[4:0]], {1'b1, 8'h00});
        chk("t1_byte1", rx_log[(rx0 + 1) % 32], {1'b0, 8'hAF});
        chk("t1_stop_pulses", stop_cnt - st0, 1);
        chk("t1_ack_edges", ack_cnt - ak0, 3);
        chk("t1_busy_after", busy, 0);
        chk("t1_rx_data_hold", rx_data, 8'hAF);
        half = 20;

        // 2: wrong address 0x3D
        rx0 = rx_cnt; st0 = stop_cnt; by0 = busy_cnt; ak0 = ack_cnt;
        i2c_start();
        send_byte(8'h7A, ack); chk("t2_nack_addr", ack, 0);
        send_byte(8'h55, ack); chk("t2_nack_data", ack, 0);
        i2c_stop();
        wait_clk(4);
        chk("t2_rx_count", rx_cnt - rx0, 0);
        chk("t2_stop_pulses", stop_cnt - st0, 0);
        chk("t2_busy_cycles", busy_cnt - by0, 0);
        chk("t2_ack_edges", ack_cnt - ak0, 0);

        // 3: read of our address is NACKed
        rx0 = rx_cnt; st0 = stop_cnt; by0 = busy_cnt;
        i2c_start();
        send_byte(8'h79, ack); chk("t3_nack_read", ack, 0);
        send_byte(8'hFF, ack); chk("t3_nack_more", ack, 0);
        i2c_stop();
        wait_clk(4);
        chk("t3_rx_count", rx_cnt - rx0, 0);
        chk("t3_stop_pulses", stop_cnt - st0, 0);
        chk("t3_busy_cycles", busy_cnt - by0, 0);

        // 4: partial byte then repeated START
        rx0 = rx_cnt; st0 = stop_cnt;
        i2c_start();
        send_byte(8'h78, ack); chk("t4_ack_addr", ack, 1);
        send_byte(8'h40, ack); chk("t4_ack_d0", ack, 1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        i2c_start();
        chk("t4_oe_rstart", sda_oe, 0);
        chk("t4_busy_rstart", busy, 0);
        send_byte(8'h78, ack); chk("t4_ack_addr2", ack, 1);
        send_byte(8'h11, ack); chk("t4_ack_d1", ack, 1);
        i2c_stop();
        wait_clk(4);
        chk("t4_rx_count", rx_cnt - rx0, 2);
        chk("t4_byte0", rx_log[rx0[4:0]], {1'b1, 8'h40});
        chk("t4_byte1", rx_log[(rx0 + 1) % 32], {1'b1, 8'h11});
        chk("t4_stop_pulses", stop_cnt - st0, 1);

        // 5: asynchronous reset in the 4th bit of a data byte
        i2c_start();
        send_byte(8'h78, ack); chk("t5_ack_addr", ack, 1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        wait_clk(half / 2);
        sda_drv = 1'b0;
        wait_clk(half / 2);
        scl_drv = 1'b1;
        wait_clk(half / 2);
        chk("t5_busy_pre", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rst_oe", sda_oe, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_rx_data", rx_data, 0);
        chk("t5_rst_rx_valid", rx_valid, 0);
        sda_drv = 1'b1;
        wait_clk(10);
        rst_n = 1'b1;
        wait_clk(10);
        rx0 = rx_cnt; st0 = stop_cnt;
        i2c_start();
        send_byte(8'h78, ack); chk("t5_ack_addr2", ack, 1);
        send_byte(8'h5A, ack); chk("t5_ack_d0", ack, 1);
        send_byte(8'hC3, ack); chk("t5_ack_d1", ack, 1);
        i2c_stop();
        wait_clk(4);
        chk("t5_rx_count", rx_cnt - rx0, 2);
        chk("t5_byte0", rx_log[rx0[4:0]], {1'b1, 8'h5A});
        chk("t5_byte1", rx_log[(rx0 + 1) % 32], {1'b0, 8'hC3});
        chk("t5_stop_pulses", stop_cnt - st0, 1);

        // 6: SDA chatter while SCL is low must not look like START/STOP
        rx0 = rx_cnt; st0 = stop_cnt;
        i2c_start();
        glitch = 1'b1;
        send_byte(8'h78, ack); chk("t6_ack_addr", ack, 1);
        send_byte(8'h3C, ack); chk("t6_ack_d0", ack, 1);
        send_byte(8'h81, ack); chk("t6_ack_d1", ack, 1);
        glitch = 1'b0;
        i2c_stop();
        i2c_start();
        i2c_stop();
        wait_clk(4);
        chk("t6_rx_count", rx_cnt - rx0, 2);
        chk("t6_byte0", rx_log[rx0[4:0]], {1'b1, 8'h3C});
        chk("t6_byte1", rx_log[(rx0 + 1) % 32], {1'b0, 8'h81});
        chk("t6_stop_pulses", stop_cnt - st0, 1);
        chk("t6_busy_after", busy, 0);

        chk("oe_stable_scl_high", oe_viol, 0);
        chk("rx_valid_one_cycle", long_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
